// File: rtl/ahb_rr_arbiter.sv
`default_nettype none

`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 4
`endif
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

// ============================================================================
// Module   : ahb_rr_arbiter
// Purpose  : Round-robin AHB bus arbiter. Master 0 is the default master and
//            is granted whenever no real master (1..N_MST-1) is requesting.
//            Unlocked tenures are capped at MAX_BEATS accepted transfers.
//            A RETRY/SPLIT first cycle forces an early re-arbitration.
//
// Ports    : HCLK       in   bus clock, rising edge
//            HRESETn    in   asynchronous active-low reset
//            HBUSREQ    in   [N_MST]  bus request per master (bit 0 ignored)
//            HLOCK      in   [N_MST]  lock request per master (bit 0 ignored)
//            HTRANS     in   address-phase transfer type
//            HREADY     in   bus ready
//            HRESP      in   bus response
//            HGRANT     out  [N_MST]  one-hot grant, registered
//            HMASTER    out  index of the address-phase owner, registered
//            HMASTLOCK  out  current address phase is locked, registered
//
// Revision : 1.0  initial release
// ============================================================================
module ahb_rr_arbiter #(
    parameter int N_MST     = 3,
    parameter int MAX_BEATS = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [N_MST-1:0]            HBUSREQ,
    input  logic [N_MST-1:0]            HLOCK,
    input  logic [`AHB_TRANS_BITS-1:0]  HTRANS,
    input  logic                        HREADY,
    input  logic [`AHB_RESP_BITS-1:0]   HRESP,
    output logic [N_MST-1:0]            HGRANT,
    output logic [`AHB_MASTER_BITS-1:0] HMASTER,
    output logic                        HMASTLOCK
);

    localparam int MB = `AHB_MASTER_BITS;

    localparam logic [`AHB_TRANS_BITS-1:0] c_TRANS_IDLE   = 2'd0;
    localparam logic [`AHB_TRANS_BITS-1:0] c_TRANS_BUSY   = 2'd1;
    localparam logic [`AHB_TRANS_BITS-1:0] c_TRANS_NONSEQ = 2'd2;
    localparam logic [`AHB_TRANS_BITS-1:0] c_TRANS_SEQ    = 2'd3;

    localparam logic [`AHB_RESP_BITS-1:0]  c_RESP_RETRY   = 2'd2;
    localparam logic [`AHB_RESP_BITS-1:0]  c_RESP_SPLIT   = 2'd3;

    localparam logic [7:0]       c_MAX_BEATS = 8'(MAX_BEATS);
    localparam logic [7:0]       c_BEAT_SAT  = 8'd255;
    localparam logic [MB-1:0]    c_RR_RESET  = MB'(N_MST - 1);
    localparam logic [N_MST-1:0] c_GRANT_M0  = N_MST'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [N_MST-1:0] grant_q,     grant_d;
    logic [MB-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [7:0]       beat_cnt_q,  beat_cnt_d;
    logic [MB-1:0]    hmaster_q,   hmaster_d;
    logic             hmastlock_q, hmastlock_d;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [N_MST-1:0] w_req;          // requests of real masters only
    logic [N_MST-1:0] w_lock;         // lock requests of real masters only
    logic [MB-1:0]    w_owner_idx;    // index of the currently granted master
    logic             w_owner_lock;   // owner is locking and still requesting
    logic             w_accept;       // a transfer is accepted this cycle
    logic             w_retry_first;  // first cycle of a RETRY/SPLIT response
    logic             w_hold_a;
    logic             w_hold_b;
    logic             w_hold_c;
    logic             w_hold;
    logic             w_retry_rearb;
    logic             w_rearb;
    logic [N_MST-1:0] w_cand;         // requests eligible for this decision
    logic             w_found;
    logic [MB-1:0]    w_win;

    // Bit 0 is the default master: it never requests or locks on its own.
    assign w_req  = HBUSREQ & ~c_GRANT_M0;
    assign w_lock = HLOCK   & ~c_GRANT_M0;

    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (grant_q[i]) begin
                w_owner_idx = MB'(i);
            end
        end
    end

    // Masking with the one-hot grant avoids an index wider than the vector.
    assign w_owner_lock  = |(grant_q & w_lock & w_req);

    assign w_accept      = HREADY &&
                           ((HTRANS == c_TRANS_NONSEQ) || (HTRANS == c_TRANS_SEQ));

    assign w_retry_first = !HREADY &&
                           ((HRESP == c_RESP_RETRY) || (HRESP == c_RESP_SPLIT));

    // (a) locked owner still requesting
    assign w_hold_a = w_owner_lock;
    // (b) a locked address phase is still in progress
    assign w_hold_b = hmastlock_q && (HTRANS != c_TRANS_IDLE);
    // (c) burst continuing and tenure still below the beat limit
    assign w_hold_c = ((HTRANS == c_TRANS_SEQ) || (HTRANS == c_TRANS_BUSY)) &&
                      (beat_cnt_q < c_MAX_BEATS);

    assign w_hold = w_hold_a || w_hold_b || w_hold_c;

    // A RETRY/SPLIT breaks a lock request or an open burst, but never a
    // locked address phase already on the bus.
    assign w_retry_rearb = w_retry_first && !w_hold_b;
    assign w_rearb       = !w_hold || w_retry_rearb;

    // The retried master sits out exactly one decision.
    always_comb begin
        w_cand = w_req;
        if (w_retry_rearb) begin
            w_cand = w_req & ~(c_GRANT_M0 << hmaster_q);
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search: rr_ptr+1 .. N_MST-1, wrap to 1 .. rr_ptr.
    // ------------------------------------------------------------------------
    always_comb begin : p_winner
        int c;
        c       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k < N_MST; k++) begin
            c = int'(rr_ptr_q) + k;
            if (c >= N_MST) begin
                c = c - (N_MST - 1);
            end
            if (!w_found && w_cand[c]) begin
                w_found = 1'b1;
                w_win   = MB'(c);
            end
        end
        // Only the excluded retried master wants the bus: give it back.
        if (!w_found && w_retry_rearb && (|w_req)) begin
            w_win = hmaster_q;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (w_rearb) begin
            grant_d = c_GRANT_M0 << w_win;
            if (w_win != '0) begin
                rr_ptr_d = w_win;
            end
        end
    end

    // Address-phase ownership only moves on a completed transfer slot.
    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (HREADY) begin
            hmaster_d   = w_owner_idx;
            hmastlock_d = w_owner_lock;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (hmaster_d != hmaster_q) begin
            beat_cnt_d = 8'd0;
        end else if (w_accept) begin
            if (HTRANS == c_TRANS_NONSEQ) begin
                beat_cnt_d = 8'd1;
            end else if (beat_cnt_q != c_BEAT_SAT) begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q     <= c_GRANT_M0;
            rr_ptr_q    <= c_RR_RESET;
            beat_cnt_q  <= 8'd0;
            hmaster_q   <= '0;
            hmastlock_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

`default_nettype wire

// File: doc/ahb_rr_arbiter.md
# ahb_rr_arbiter

Round-robin AHB bus arbiter for the shared AHB interconnect. It takes bus requests and lock requests from the bus masters, plus the default master at index 0. It drives the one-hot grant vector, the registered HMASTER and HMASTLOCK that steer the master-to-slave mux, and enforces a per-tenure beat limit so that no unlocked master can starve the others. It also handles early-burst handover and RETRY/SPLIT re-arbitration.

## Interface
Parameters:
- N_MST, 3, number of master slots including default master 0; must be ≤ 2^`AHB_MASTER_BITS
- MAX_BEATS, 16, accepted transfers allowed per unlocked tenure before forced re-arbitration; range 1..255

Ports:
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HBUSREQ  in  N_MST  bus request per master; bit 0 ignored
- HLOCK  in  N_MST  lock request per master; bit 0 ignored
- HTRANS  in  `AHB_TRANS_BITS  current address-phase transfer type from the M2S mux
- HREADY  in  1  bus ready from the S2M mux
- HRESP  in  `AHB_RESP_BITS  bus response from the S2M mux
- HGRANT  out  N_MST  one-hot grant, registered
- HMASTER  out  `AHB_MASTER_BITS  index of the address-phase owner, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Encodings: HTRANS uses IDLE=0, BUSY=1, NONSEQ=2, SEQ=3. HRESP uses OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
- State consists of:
  - the grant register;
  - rr_ptr, the last real master granted, in range 1..N_MST-1;
  - beat_cnt, 8 bits;
  - the HMASTER and HMASTLOCK registers.
- Accepted beat: HTRANS ∈ {NONSEQ, SEQ} while HREADY=1.
- beat_cnt updates on each accepted beat:
  - NONSEQ sets it to 1;
  - SEQ increments it, saturating at 255.
  - It clears to 0 when HMASTER changes.
- `hold` is true, meaning the grant is kept, when any of the following holds:
  - (a) HLOCK[owner]=1 and the owner is still requesting;
  - (b) HMASTLOCK=1 and HTRANS≠IDLE;
  - (c) HTRANS ∈ {SEQ, BUSY} and beat_cnt < MAX_BEATS.
- Here, "owner" is the master currently granted.
- `rearb` is true in either of these cases:
  - !hold;
  - a RETRY or SPLIT first cycle is seen, i.e. HREADY=0 and HRESP ∈ {RETRY, SPLIT}. This overrides hold (a) and (c) but not (b).
- Round-robin winner:
  - Search for a set HBUSREQ starting at rr_ptr+1, wrapping over indices 1..N_MST-1 and ending at rr_ptr inclusive.
  - The first set HBUSREQ wins.
  - If none is set, grant master 0.
- On rearb:
  - HGRANT is loaded with the winner on the next edge.
  - rr_ptr is updated to the winner if the winner ≠ 0.
- On a RETRY/SPLIT rearb, the retried master is excluded from the search for that single decision. If it is the only requester, it is re-granted.
- Handover:
  - When HREADY=1, HMASTER is loaded with the index of HGRANT.
  - When HREADY=1, HMASTLOCK is loaded with HLOCK[index of HGRANT] & HBUSREQ[index of HGRANT].
  - When HREADY=0, HMASTER and HMASTLOCK hold.
- Beat limit:
  - When beat_cnt reaches MAX_BEATS mid-burst, the grant is removed.
  - The master must terminate the burst and re-request.
  - Locked tenures are exempt from the limit.
- ERROR responses do not affect arbitration.
- HGRANT is always exactly one-hot.

## Timing
- Reset (HRESETn=0, asynchronous): HGRANT=1 (master 0), HMASTER=0, HMASTLOCK=0, rr_ptr=N_MST-1 so master 1 has first priority, beat_cnt=0.
- Request to grant: 1 cycle. HBUSREQ sampled at edge k gives HGRANT valid after edge k when rearb is true at edge k.
- Grant to HMASTER: HMASTER updates on the first edge with HREADY=1 after HGRANT changes. Minimum latency is 1 cycle; wait states stretch it.
- Simultaneous requests are resolved by rr_ptr only. There is no fixed priority beyond master 0 as the fallback.
- A request dropped in the same cycle a grant is issued: the grant stands for one cycle, then rearb reselects, because hold is false with HTRANS=IDLE.
- Reset deasserted mid-burst: the arbiter restarts from the reset state. Masters see HGRANT removed.

## Test plan
- Reset, then HBUSREQ=3'b110 held, with single NONSEQ transfers and HREADY=1 -> grants alternate M1, M2, M1, M2. HMASTER lags HGRANT by 1 cycle.
- No requests -> HGRANT=3'b001, HMASTER=0. Raise HBUSREQ[2] -> HGRANT=3'b100 next cycle, HMASTER=2 the cycle after.
- M1 runs an INCR burst of 20 SEQ beats with MAX_BEATS=16 while M2 requests -> grant moves to M2 after the 16th accepted beat. beat_cnt resets to 0 on the HMASTER change.
- M1 asserts HLOCK with a 20-beat burst while M2 requests -> M1 keeps the grant for all 20 beats and HMASTLOCK=1 throughout. M2 is granted only after M1 drops HLOCK and HTRANS=IDLE.
- Both masters request, and M1's slave returns RETRY (HREADY=0, HRESP=2) -> HGRANT=3'b100 on the next edge. M1 is re-granted on the next rearb.
- HREADY=0 for 3 cycles during handover -> HGRANT changes, but HMASTER and HMASTLOCK hold until the first HREADY=1 edge.
